// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and rotate-right FSM state encoding
package alu_pkg;

   localparam int ALU_WIDTH = 4;
   localparam int ROT_CNT_W = 2;

   typedef enum logic [1:0] {
      ROR_IDLE  = 2'd0,
      ROR_SHIFT = 2'd1,
      ROR_DONE  = 2'd2
   } ror_state_t;

endpackage

// File: rtl/alu_ror_serial_if.sv
// rtl/alu_ror_serial_if.sv - start/busy/done handshake bundle for the serial rotate-right unit
interface alu_ror_serial_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] R;
   logic             busy;
   logic             done;
   logic             carry;

   modport master (output start, A, B, input R, busy, done, carry);
   modport slave  (input start, A, B, output R, busy, done, carry);

endinterface

// File: rtl/alu_ror1_step.sv
// rtl/alu_ror1_step.sv - combinational single-position rotate-right with rotated-out bit
module alu_ror1_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             carry
);

   assign q     = {d[0], d[WIDTH-1:1]};
   assign carry = d[0];

endmodule

// File: rtl/alu_ror_serial.sv
// rtl/alu_ror_serial.sv - multi-cycle rotate-right, one bit position per clock
module alu_ror_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = ROT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_ror_serial_if.slave  bus
);

   ror_state_t       state;
   ror_state_t       state_nxt;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic [CNT_W-1:0] amt_in;
   logic [WIDTH-1:0] step_q;
   logic             step_carry;
   logic             unused_b_hi;

   // Only the low CNT_W bits of B select the rotate amount.
   assign amt_in      = bus.B[CNT_W-1:0];
   assign unused_b_hi = ^bus.B[WIDTH-1:CNT_W];

   alu_ror1_step #(.WIDTH(WIDTH)) u_step (
      .d     (acc),
      .q     (step_q),
      .carry (step_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ROR_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ROR_IDLE: begin
            if (bus.start) begin
               state_nxt = (amt_in == '0) ? ROR_DONE : ROR_SHIFT;
            end
         end
         ROR_SHIFT: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = ROR_DONE;
            end
         end
         ROR_DONE: state_nxt = ROR_IDLE;
         default:  state_nxt = ROR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state)
            ROR_IDLE: begin
               if (bus.start) begin
                  acc     <= bus.A;
                  cnt     <= amt_in;
                  carry_q <= 1'b0;
               end
            end
            ROR_SHIFT: begin
               acc     <= step_q;
               carry_q <= step_carry;
               cnt     <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decode only registered state, so no path from start/A/B.
   assign bus.R     = acc;
   assign bus.busy  = (state != ROR_IDLE);
   assign bus.done  = (state == ROR_DONE);
   assign bus.carry = carry_q;

endmodule

// File: tb/tb_alu_ror_serial.sv
// tb/tb_alu_ror_serial.sv - directed and random checks of the serial rotate-right unit
module tb_alu_ror_serial;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_ror_serial_if #(.WIDTH(4)) bus ();

   alu_ror_serial dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] rol(input logic [3:0] a, input int n);
      logic [3:0] r;
      r = (a << n) | (a >> (4 - n));
      return r;
   endfunction

   // poke > 0 re-asserts start with a different operand on that edge count
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_r, input logic exp_c, input int poke);
      int edges;
      int busy_cyc;
      int amt;
      bit seen;
      amt      = int'(b[1:0]);
      edges    = 0;
      busy_cyc = 0;
      seen     = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      while (!seen && edges < 10) begin
         @(posedge clk);
         #1;
         edges++;
         bus.start = (edges == poke);
         bus.A     = (edges == poke) ? 4'hF : ~a;
         bus.B     = b + 4'd1;
         if (bus.busy) busy_cyc++;
         seen = bus.done;
      end
      bus.start = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(edges), 32'(amt + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(amt + 1));
      check({tag, "_R"}, 32'(bus.R), 32'(exp_r));
      check({tag, "_carry"}, 32'(bus.carry), 32'(exp_c));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'({bus.done, bus.busy}), 32'd0);
      check({tag, "_R_hold"}, 32'(bus.R), 32'(exp_r));
   endtask

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rexp;
      int         ramt;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = 4'h0;
      bus.B     = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'({bus.R, bus.busy, bus.done, bus.carry}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("ror1",      4'b1001, 4'd1,    4'b1100, 1'b1, 0);
      run_op("ror2",      4'b0110, 4'd2,    4'b1001, 1'b1, 0);
      run_op("ror2_hi",   4'b0110, 4'b0110, 4'b1001, 1'b1, 0);
      run_op("ror3",      4'b0001, 4'd3,    4'b0010, 1'b0, 0);
      run_op("ror0",      4'b1010, 4'd0,    4'b1010, 1'b0, 0);
      run_op("restart",   4'b1000, 4'd3,    4'b0001, 1'b0, 1);

      // Abort mid-operation with an asynchronous reset.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 4'b1001;
      bus.B     = 4'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_R", 32'(bus.R), 32'd0);
      check("abort_flags", 32'({bus.busy, bus.done, bus.carry}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("abort_no_done", 32'({bus.busy, bus.done}), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_reset", 4'b1001, 4'd3, 4'b0011, 1'b0, 0);

      for (int i = 0; i < 200; i++) begin
         ra   = 4'($urandom_range(0, 15));
         rb   = 4'($urandom_range(0, 15));
         ramt = int'(rb[1:0]);
         rexp = rol(ra, (4 - ramt) % 4);
         run_op("rand", ra, rb, rexp, (ramt != 0) ? rexp[3] : 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
